ad_sample_capture: RTL and testbench

Captures one frame of parallel ADC samples, timed by the `ad_clk` strobe from the sample-clock generator, into an on-chip buffer. It tracks the frame minimum and maximum and raises `done` when the frame is complete. It sits directly downstream of the sample-clock generator, in the same `clk_20b` (200 MHz) domain. The measurement logic reads the buffer back through a synchronous read port.

---
 rtl/ad_capture_pkg.sv | 19 +
 rtl/ad_capture_ram.sv | 34 +++
 rtl/ad_sample_capture.sv | 135 +++++++++++++
 tb/tb_ad_sample_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ad_capture_pkg
// Brief    : Shared state encoding and default sizes for the ADC frame capture.
// Revision : 1.0 - initial release
// ============================================================================
package ad_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

    localparam int AD_DATA_W = 12;
    localparam int AD_DEPTH  = 256;

endpackage : ad_capture_pkg
`default_nettype wire

// File: rtl/ad_capture_ram.sv
`default_nettype none
// ============================================================================
// Module   : ad_capture_ram
// Brief    : Simple dual-port frame buffer, one write port, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module ad_capture_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk_20b,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // No reset on the array or read register so block RAM can be inferred.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk_20b) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data;

endmodule : ad_capture_ram
`default_nettype wire

// File: rtl/ad_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : ad_sample_capture
// Brief    : Strobe-timed capture of one ADC frame with running min/max.
// Revision : 1.0 - initial release
// ============================================================================
import ad_capture_pkg::*;

module ad_sample_capture #(
    parameter int DATA_W = AD_DATA_W,
    parameter int DEPTH  = AD_DEPTH,
    parameter int AW     = 8
) (
    input  logic              clk_20b,
    input  logic              rst_n,
    input  logic              ad_clk,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);

    cap_state_t        r_state;
    cap_state_t        w_state_next;
    logic              r_ad_clk_q;
    logic              r_ad_clk_qq;
    logic [DATA_W-1:0] r_ad_data_q;
    logic [AW-1:0]     r_wr_ptr;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_min;
    logic              r_rd_live;
    logic [DATA_W-1:0] w_ram_q;
    logic              w_rise;
    logic              w_start_ok;
    logic              w_wr_en;

    always_ff @(posedge clk_20b or negedge rst_n) begin
        if (!rst_n) begin
            r_ad_clk_q  <= 1'b0;
            r_ad_clk_qq <= 1'b0;
            r_ad_data_q <= '0;
        end else begin
            r_ad_clk_q  <= ad_clk;
            r_ad_clk_qq <= r_ad_clk_q;
            r_ad_data_q <= ad_data;
        end
    end

    assign w_rise     = r_ad_clk_q & ~r_ad_clk_qq;
    assign w_start_ok = start && (r_state != CAPTURE);
    // Abort takes priority over a coincident sample, so that sample is dropped.
    assign w_wr_en    = (r_state == CAPTURE) && w_rise && !abort;

    always_ff @(posedge clk_20b or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = CAPTURE;
            end
            CAPTURE: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_rise && (r_wr_ptr == C_LAST_ADDR)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) w_state_next = CAPTURE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_20b or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_max    <= '0;
            r_min    <= '0;
        end else if (w_start_ok) begin
            r_wr_ptr <= '0;
            r_max    <= '0;
            r_min    <= '1;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_ad_data_q > r_max) r_max <= r_ad_data_q;
            if (r_ad_data_q < r_min) r_min <= r_ad_data_q;
        end
    end

    // The RAM read register has no reset; hold rd_data at zero until it has
    // been clocked at least once out of reset.
    always_ff @(posedge clk_20b or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_live <= 1'b0;
        end else begin
            r_rd_live <= 1'b1;
        end
    end

    ad_capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_20b (clk_20b),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr),
        .wr_data (r_ad_data_q),
        .rd_addr (rd_addr),
        .rd_data (w_ram_q)
    );

    assign busy    = (r_state == CAPTURE);
    assign done    = (r_state == DONE);
    assign max_val = r_max;
    assign min_val = r_min;
    assign rd_data = r_rd_live ? w_ram_q : '0;

endmodule : ad_sample_capture
`default_nettype wire

// File: tb/tb_ad_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad_sample_capture
// Brief    : Directed/random bench for ad_sample_capture with a frame model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_ad_sample_capture;

    localparam int DW    = 12;
    localparam int DEPTH = 256;

    logic          clk_20b = 1'b0;
    logic          rst_n;
    logic          ad_clk;
    logic [DW-1:0] ad_data;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [DW-1:0] max_val;
    logic [DW-1:0] min_val;
    logic [7:0]    rd_addr;
    logic [DW-1:0] rd_data;

    ad_sample_capture dut (
        .clk_20b (clk_20b),
        .rst_n   (rst_n),
        .ad_clk  (ad_clk),
        .ad_data (ad_data),
        .start   (start),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .max_val (max_val),
        .min_val (min_val),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #2.5 clk_20b = ~clk_20b;

    int checks = 0;
    int errors = 0;

    // Stimulus generator state
    int per      = 20;
    int ph       = 0;
    int mode     = 0;   // 0 ramp, 1 constant 12'h800, 2 random
    int ramp_cnt = 0;

    // Reference model: frame contents as a queue plus capture/done flags
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    int            m_frame[$];
    logic [DW-1:0] mem_m[DEPTH];
    logic          pend_ev   = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic          prev_clk  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A strobe edge seen at the pin in one cycle becomes a write in the next,
    // carrying the data that was on the pins alongside that edge.
    task automatic model_update(input logic st, input logic ab, input logic ev, input logic [DW-1:0] d);
        if (m_busy) begin
            if (ab) begin
                m_busy = 1'b0;
            end else if (ev) begin
                mem_m[m_frame.size()] = d;
                m_frame.push_back(int'(d));
                if (m_frame.size() == DEPTH) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (st) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_frame.delete();
        end
    endtask

    task automatic step(input logic st, input logic ab);
        ph = (ph + 1) % per;
        if (ph == 0) begin
            case (mode)
                0:       begin ad_data = DW'(ramp_cnt); ramp_cnt++; end
                1:       ad_data = 12'h800;
                default: ad_data = DW'($urandom);
            endcase
        end
        ad_clk = (ph >= per / 2);
        start  = st;
        abort  = ab;
        model_update(st, ab, pend_ev, pend_data);
        pend_ev   = ad_clk && !prev_clk;
        pend_data = ad_data;
        prev_clk  = ad_clk;
        @(negedge clk_20b);
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic restart_gen(input int p, input int md);
        per      = p;
        mode     = md;
        ph       = p - 1;
        ramp_cnt = 0;
    endtask

    // Runs until the model frame reaches target samples or capture ends;
    // optionally sprinkles ignored start pulses mid-capture.
    task automatic run(input int target, input bit jitter_start);
        int n      = 0;
        int budget = (target + 2) * per + 20;
        while (m_busy && m_frame.size() < target && n < budget) begin
            step(jitter_start && ($urandom_range(0, 40) == 0), 1'b0);
            n++;
        end
        if (target == DEPTH) chk("frame_done", {31'd0, done}, 32'd1);
    endtask

    task automatic check_frame();
        int mn = (1 << DW) - 1;
        int mx = 0;
        foreach (m_frame[i]) begin
            if (m_frame[i] < mn) mn = m_frame[i];
            if (m_frame[i] > mx) mx = m_frame[i];
        end
        chk("frame_len", done ? 32'(DEPTH) : 32'(m_frame.size()), 32'(DEPTH));
        chk("max_val", {20'd0, max_val}, 32'(mx));
        chk("min_val", {20'd0, min_val}, 32'(mn));
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 8'(a);
            step(1'b0, 1'b0);
            chk("rd_data", {20'd0, rd_data}, {20'd0, mem_m[a]});
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ad_clk    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        m_busy    = 1'b0;
        m_done    = 1'b0;
        pend_ev   = 1'b0;
        prev_clk  = 1'b0;
        ph        = per - 1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_max", {20'd0, max_val}, 32'd0);
        chk("rst_min", {20'd0, min_val}, 32'd0);
        chk("rst_rd_data", {20'd0, rd_data}, 32'd0);
        repeat (3) @(negedge clk_20b);
        rst_n = 1'b1;
        @(negedge clk_20b);
        chk("post_rst_min", {20'd0, min_val}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        ad_data = '0;
        rd_addr = '0;
        rst_n   = 1'b1;
        @(negedge clk_20b);
        do_reset();

        // Ramp frame at a 20-cycle strobe period
        restart_gen(20, 0);
        step(1'b1, 1'b0);
        run(DEPTH, 1'b0);
        chk("ramp_max", {20'd0, max_val}, 32'd255);
        chk("ramp_min", {20'd0, min_val}, 32'd0);
        check_frame();

        // Constant data at the minimum strobe period, restarted from DONE
        restart_gen(4, 1);
        step(1'b1, 1'b0);
        run(DEPTH, 1'b0);
        chk("const_max", {20'd0, max_val}, 32'h800);
        chk("const_min", {20'd0, min_val}, 32'h800);
        check_frame();

        // Start lands in the same cycle as a strobe rise: that sample is skipped
        restart_gen(6, 2);
        for (int i = 0; i < 20 && !pend_ev; i++) step(1'b0, 1'b0);
        chk("coincident_setup", {31'd0, pend_ev}, 32'd1);
        step(1'b1, 1'b0);
        chk("coincident_skip", 32'(m_frame.size()), 32'd0);
        run(DEPTH, 1'b0);
        check_frame();

        // Abort ignored in DONE, start wins over abort, then abort mid-frame
        restart_gen(8, 2);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        run(100, 1'b0);
        step(1'b0, 1'b1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        run(DEPTH, 1'b0);
        check_frame();

        // Start pulses during capture are ignored
        restart_gen(5, 2);
        step(1'b1, 1'b0);
        run(DEPTH, 1'b1);
        check_frame();

        // Reset mid-frame, then a clean frame and a recapture from DONE
        restart_gen(10, 2);
        step(1'b1, 1'b0);
        run(50, 1'b0);
        do_reset();
        step(1'b1, 1'b0);
        run(DEPTH, 1'b0);
        check_frame();
        step(1'b1, 1'b0);
        chk("recapture_done_clear", {31'd0, done}, 32'd0);
        run(DEPTH, 1'b0);
        check_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ad_sample_capture
`default_nettype wire
